pim_dma_cmd_queue: RTL and testbench
====================================

# pim_dma_cmd_queue

Command queue and dispatcher between the CPU's PIM custom-instruction decode and the PIM DMA engine. It accepts PIM transfer commands (pim_write / pim_compute / pim_load) from the core and buffers them in a small FIFO. It issues each command to the DMA as a single-cycle enable pulse with stable operands, then tracks the DMA's busy handshake until completion. The core therefore only stalls when the queue is full or on an explicit fence, not for the whole transfer.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- BUSY_TIMEOUT, 8, cycles allowed between enable pulse and DMA busy rising
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  core presents a PIM command
- o_cmd_ready  out  1  queue can accept; `= !full`
- i_cmd_funct3  in  3  3'b001 write weight, 3'b010 compute (write activation), 3'b100 load result
- i_cmd_rs1  in  32  memory address (word aligned)
- i_cmd_rs2  in  32  [12:0] transfer count (words), [19:16] PIM select; other bits ignored
- i_fence  in  1  core waits for all queued work to finish
- o_fence_stall  out  1  `i_fence && !(empty && dispatcher idle)`
- o_dma_en  out  1  one-cycle start pulse to DMA
- o_dma_funct3  out  3  operands to DMA, held stable from pulse until next pop
- o_dma_sel_pim  out  4
- o_dma_size  out  13
- o_dma_mem_addr  out  32
- i_dma_busy  in  1  DMA busy status
- i_err_clr  in  1  clears sticky error flags
- o_err_illegal  out  1  sticky: illegal command dropped
- o_err_timeout  out  1  sticky: DMA never went busy
- o_done_cnt  out  16  completed commands, wraps at 2^16

## Operation
- **Enqueue**
  - Accept on `i_cmd_valid && o_cmd_ready`.
  - A command is illegal if funct3 is not one-hot among {001, 010, 100}, if size == 0, or if rs1[1:0] != 0.
  - An illegal command is accepted (ready honoured) but not stored, and sets o_err_illegal.
- **Dispatcher FSM**
  - D_IDLE: if !empty, pop the head into the output operand registers → D_ISSUE. Otherwise stay.
  - D_ISSUE: o_dma_en = 1 for exactly this cycle → D_WAIT_BUSY.
  - D_WAIT_BUSY:
    - if i_dma_busy → D_WAIT_DONE;
    - else if timer reaches BUSY_TIMEOUT → set o_err_timeout, → D_IDLE. The command is not retried and not counted.
  - D_WAIT_DONE: when !i_dma_busy → increment o_done_cnt, → D_IDLE.
- **FIFO**
  - Read/write pointers are log2(DEPTH)+1 bits; full/empty come from MSB comparison.
  - Push and pop in the same cycle are legal when neither full nor empty.
  - A push to an empty queue is not bypassed to the dispatcher.
- **Fence**: purely combinational stall. It does not block enqueue; the core is expected not to issue while stalled.
- **Errors**
  - i_err_clr clears both sticky flags.
  - If a set event and i_err_clr occur in the same cycle, the set wins.

## Timing
- All outputs reset to 0; FSM resets to D_IDLE; pointers, timer and counter reset to 0.
- Reset mid-transfer drops all queued commands. The DMA is expected to share the same reset.
- Latency from a command accepted at cycle t into an empty queue with the dispatcher idle:
  - t+1: head visible, pop;
  - t+2: o_dma_en;
  - t+3: DMA busy expected.
- Minimum gap between two enable pulses: 4 cycles (ISSUE, WAIT_BUSY, ≥1 WAIT_DONE, IDLE).
- Operand outputs change only on pop, so they are stable through the pulse and the DMA's capture cycle.
- Timer clears on entry to D_WAIT_BUSY and counts each cycle spent there.
- i_dma_busy low in D_WAIT_BUSY for fewer than BUSY_TIMEOUT cycles is normal and causes no error.
- o_cmd_ready deasserts the cycle after the DEPTH-th stored push. A pop while full frees a slot in the next cycle (no same-cycle pass-through).
- o_done_cnt wraps 0xFFFF → 0x0000.

## Structure
- Shared package pim_dma_pkg:
  - funct3 localparams PIM_WRITE/PIM_COMPUTE/PIM_LOAD;
  - packed struct pim_cmd_t {funct3, sel_pim, size, mem_addr};
  - dispatcher state enum.
- The DMA engine takes the same funct3 constants from this package.
- One sub-module: pim_cmd_fifo (parameterised DEPTH, pim_cmd_t payload, push/pop/full/empty).

## Test plan
- Single command: funct3=001, rs1=0x0000_1000, rs2=0x0002_0010 → o_dma_en at t+2 with sel_pim=2, size=16, addr=0x1000. DMA model busy for 20 cycles → o_done_cnt=1, FSM back to D_IDLE.
- Back-to-back fill: 5 legal commands with DEPTH=4 while the DMA is busy → ready low after the 4th stored push. Commands dispatch in order; the 5th is accepted after the first pop; o_done_cnt=5.
- Illegal commands: funct3=011, size=0, rs1=0x1002 → none dispatched, o_err_illegal=1. i_err_clr → 0.
- Timeout: DMA model never asserts busy → o_err_timeout=1 exactly BUSY_TIMEOUT cycles after the pulse. The next queued command still issues.
- Fence: i_fence with 2 commands queued → o_fence_stall stays high until the second busy falls, low the following cycle.
- Reset mid-op: assert i_rst_n low while in D_WAIT_DONE with 3 queued → all outputs 0, queue empty, o_cmd_ready=1 after release.

Source files
------------

// File: rtl/pim_dma_pkg.sv
// Shared definitions for the PIM DMA command path: funct3 encodings, the queued
// command payload and the dispatcher state encoding.
package pim_dma_pkg;

   localparam logic [2:0] PIM_WRITE   = 3'b001;
   localparam logic [2:0] PIM_COMPUTE = 3'b010;
   localparam logic [2:0] PIM_LOAD    = 3'b100;

   localparam logic [1:0] D_IDLE      = 2'd0;
   localparam logic [1:0] D_ISSUE     = 2'd1;
   localparam logic [1:0] D_WAIT_BUSY = 2'd2;
   localparam logic [1:0] D_WAIT_DONE = 2'd3;

   typedef logic [1:0] disp_state_t;

   typedef struct packed {
      logic [2:0]  funct3;
      logic [3:0]  sel_pim;
      logic [12:0] size;
      logic [31:0] mem_addr;
   } pim_cmd_t;

   function automatic logic cmd_is_legal(input pim_cmd_t cmd);
      logic f3_ok;
      f3_ok = (cmd.funct3 == PIM_WRITE) || (cmd.funct3 == PIM_COMPUTE) ||
              (cmd.funct3 == PIM_LOAD);
      return f3_ok && (cmd.size != '0) && (cmd.mem_addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/pim_dma_cmd_queue_if.sv
// Core-command, fence, DMA-handshake and status signals of the PIM command queue.
// The queue uses the slave modport; the core/DMA side uses master.
interface pim_dma_cmd_queue_if;

   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic [2:0]  i_cmd_funct3;
   logic [31:0] i_cmd_rs1;
   logic [31:0] i_cmd_rs2;
   logic        i_fence;
   logic        o_fence_stall;
   logic        o_dma_en;
   logic [2:0]  o_dma_funct3;
   logic [3:0]  o_dma_sel_pim;
   logic [12:0] o_dma_size;
   logic [31:0] o_dma_mem_addr;
   logic        i_dma_busy;
   logic        i_err_clr;
   logic        o_err_illegal;
   logic        o_err_timeout;
   logic [15:0] o_done_cnt;

   modport slave (
      input  i_cmd_valid, i_cmd_funct3, i_cmd_rs1, i_cmd_rs2, i_fence, i_dma_busy,
             i_err_clr,
      output o_cmd_ready, o_fence_stall, o_dma_en, o_dma_funct3, o_dma_sel_pim,
             o_dma_size, o_dma_mem_addr, o_err_illegal, o_err_timeout, o_done_cnt
   );

   modport master (
      output i_cmd_valid, i_cmd_funct3, i_cmd_rs1, i_cmd_rs2, i_fence, i_dma_busy,
             i_err_clr,
      input  o_cmd_ready, o_fence_stall, o_dma_en, o_dma_funct3, o_dma_sel_pim,
             o_dma_size, o_dma_mem_addr, o_err_illegal, o_err_timeout, o_done_cnt
   );

endinterface

// File: rtl/pim_cmd_fifo.sv
// Power-of-two FIFO of PIM commands; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module pim_cmd_fifo
   import pim_dma_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  logic     i_push,
   input  pim_cmd_t i_data,
   input  logic     i_pop,
   output pim_cmd_t o_data,
   output logic     o_full,
   output logic     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   pim_cmd_t    mem_q [DEPTH];
   pim_cmd_t    mem_d [DEPTH];

   always_comb begin
      // NOTE: every always_comb target gets a default first, so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (i_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = i_data;
         wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (i_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   assign o_empty = (wr_ptr_q == rd_ptr_q);
   assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pim_dma_cmd_queue.sv
// Buffers PIM commands from the core and issues them one at a time to the DMA,
// tracking its busy handshake so the core only stalls on a full queue or fence.
module pim_dma_cmd_queue
   import pim_dma_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int BUSY_TIMEOUT = 8
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   pim_dma_cmd_queue_if.slave  bus
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

   disp_state_t  state_q, state_d;
   pim_cmd_t     op_q, op_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [15:0]  done_q, done_d;
   logic         err_ill_q, err_ill_d;
   logic         err_to_q, err_to_d;

   pim_cmd_t in_cmd, head_cmd;
   logic     fifo_full, fifo_empty;
   logic     accept, push, pop, illegal_set, timeout_set;
   logic     unused_rs2_bits;

   assign in_cmd = '{funct3:   bus.i_cmd_funct3,
                     sel_pim:  bus.i_cmd_rs2[19:16],
                     size:     bus.i_cmd_rs2[12:0],
                     mem_addr: bus.i_cmd_rs1};
   assign unused_rs2_bits = ^{bus.i_cmd_rs2[31:20], bus.i_cmd_rs2[15:13]};

   // Illegal commands are still handshaken so the core never deadlocks on them.
   assign accept      = bus.i_cmd_valid && !fifo_full;
   assign push        = accept && cmd_is_legal(in_cmd);
   assign illegal_set = accept && !cmd_is_legal(in_cmd);
   assign pop         = (state_q == D_IDLE) && !fifo_empty;

   pim_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_data  (in_cmd),
      .i_pop   (pop),
      .o_data  (head_cmd),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      timer_d     = timer_q;
      done_d      = done_q;
      timeout_set = 1'b0;
      case (state_q)
         D_IDLE: begin
            if (!fifo_empty) begin
               op_d    = head_cmd;
               state_d = D_ISSUE;
            end
         end
         D_ISSUE: begin
            timer_d = '0;
            state_d = D_WAIT_BUSY;
         end
         D_WAIT_BUSY: begin
            // Busy low for BUSY_TIMEOUT consecutive cycles here abandons the command.
            if (bus.i_dma_busy) begin
               state_d = D_WAIT_DONE;
            end else if (timer_q == TIMER_LAST) begin
               timeout_set = 1'b1;
               state_d     = D_IDLE;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end
         D_WAIT_DONE: begin
            if (!bus.i_dma_busy) begin
               done_d  = done_q + 16'd1;
               state_d = D_IDLE;
            end
         end
         default: state_d = D_IDLE;
      endcase
   end

   assign err_ill_d = illegal_set || (err_ill_q && !bus.i_err_clr);
   assign err_to_d  = timeout_set || (err_to_q && !bus.i_err_clr);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= D_IDLE;
         op_q      <= '0;
         timer_q   <= '0;
         done_q    <= '0;
         err_ill_q <= 1'b0;
         err_to_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         timer_q   <= timer_d;
         done_q    <= done_d;
         err_ill_q <= err_ill_d;
         err_to_q  <= err_to_d;
      end
   end

   assign bus.o_cmd_ready    = !fifo_full;
   assign bus.o_fence_stall  = bus.i_fence && !(fifo_empty && (state_q == D_IDLE));
   assign bus.o_dma_en       = (state_q == D_ISSUE);
   assign bus.o_dma_funct3   = op_q.funct3;
   assign bus.o_dma_sel_pim  = op_q.sel_pim;
   assign bus.o_dma_size     = op_q.size;
   assign bus.o_dma_mem_addr = op_q.mem_addr;
   assign bus.o_err_illegal  = err_ill_q;
   assign bus.o_err_timeout  = err_to_q;
   assign bus.o_done_cnt     = done_q;

endmodule

// File: tb/tb_pim_dma_cmd_queue.sv
// Directed bench for pim_dma_cmd_queue with a behavioural DMA that answers each
// enable pulse with a programmable busy delay/length, or stays silent.
module tb_pim_dma_cmd_queue;
   import pim_dma_pkg::*;

   localparam int DEPTH = 4;
   localparam int BT    = 8;
   localparam int BOUND = 300;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int cyc       = 0;
   int pass_cnt  = 0;
   int total_cnt = 0;
   int exp_done  = 0;

   int dma_len   = 20;
   int dma_delay = 0;
   bit dma_mute  = 1'b0;
   int len_cnt   = 0;
   int dly_cnt   = 0;
   pim_cmd_t    model_cmd;
   pim_cmd_t    dma_log[$];
   int          done_cyc_q[$];
   logic [15:0] done_prev = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pim_dma_cmd_queue_if bus ();

   pim_dma_cmd_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // DMA model: logs every pulse, then raises busy dma_delay cycles later for dma_len edges.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.i_dma_busy = 1'b0;
         len_cnt = 0;
         dly_cnt = 0;
      end else begin
         if (len_cnt > 0) begin
            len_cnt--;
            if (len_cnt == 0) bus.i_dma_busy = 1'b0;
         end else if (dly_cnt > 0) begin
            dly_cnt--;
            if (dly_cnt == 0) begin
               bus.i_dma_busy = 1'b1;
               len_cnt = dma_len;
            end
         end
         if (bus.o_dma_en === 1'b1) begin
            model_cmd.funct3   = bus.o_dma_funct3;
            model_cmd.sel_pim  = bus.o_dma_sel_pim;
            model_cmd.size     = bus.o_dma_size;
            model_cmd.mem_addr = bus.o_dma_mem_addr;
            dma_log.push_back(model_cmd);
            if (!dma_mute) begin
               if (dma_delay == 0) begin
                  bus.i_dma_busy = 1'b1;
                  len_cnt = dma_len;
               end else begin
                  dly_cnt = dma_delay;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (bus.o_done_cnt !== done_prev) begin
         done_prev = bus.o_done_cnt;
         done_cyc_q.push_back(cyc);
      end
   end

   task automatic push_cmd(input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] rs2, output int acc);
      int n;
      @(negedge clk);
      bus.i_cmd_valid  = 1'b1;
      bus.i_cmd_funct3 = f3;
      bus.i_cmd_rs1    = rs1;
      bus.i_cmd_rs2    = rs2;
      n = 0;
      while (bus.o_cmd_ready !== 1'b1 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      acc = cyc;
      total_cnt++;
      if (n >= BOUND) $display("FAIL push_accept: ready never rose for addr %0h after %0d cycles", rs1, n);
      else pass_cnt++;
      @(posedge clk);
      #1 bus.i_cmd_valid = 1'b0;
   endtask

   task automatic wait_en(output int c);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.o_dma_en !== 1'b1 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      c = cyc;
      total_cnt++;
      if (n >= BOUND) $display("FAIL wait_en: no enable pulse within %0d cycles", n);
      else pass_cnt++;
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.o_done_cnt !== 16'(target) && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      total_cnt++;
      if (n >= BOUND) $display("FAIL wait_done: done_cnt %0d, required %0d", bus.o_done_cnt, target);
      else pass_cnt++;
   endtask

   task automatic clear_errs();
      @(negedge clk);
      bus.i_err_clr = 1'b1;
      @(negedge clk);
      bus.i_err_clr = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      bus.i_fence = 1'b1;
      #1;
      total_cnt++; if (bus.o_cmd_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.o_cmd_ready); else pass_cnt++;
      total_cnt++; if (bus.o_dma_en !== 1'b0) $display("FAIL rst_en: got %b want 0", bus.o_dma_en); else pass_cnt++;
      total_cnt++; if ({bus.o_dma_funct3, bus.o_dma_sel_pim, bus.o_dma_size, bus.o_dma_mem_addr} !== 52'd0)
         $display("FAIL rst_operands: got %0h want 0", {bus.o_dma_funct3, bus.o_dma_sel_pim, bus.o_dma_size, bus.o_dma_mem_addr}); else pass_cnt++;
      total_cnt++; if (bus.o_done_cnt !== 16'd0) $display("FAIL rst_done: got %0d want 0", bus.o_done_cnt); else pass_cnt++;
      total_cnt++; if ({bus.o_err_illegal, bus.o_err_timeout} !== 2'b00) $display("FAIL rst_errs: got %b want 00", {bus.o_err_illegal, bus.o_err_timeout}); else pass_cnt++;
      total_cnt++; if (bus.o_fence_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", bus.o_fence_stall); else pass_cnt++;
      bus.i_fence = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int acc, e;
      dma_len = 20;
      dma_log.delete();
      push_cmd(PIM_WRITE, 32'h0000_1000, 32'h0002_0010, acc);
      wait_en(e);
      total_cnt++; if (e !== acc + 2) $display("FAIL single_latency: pulse at cycle %0d want %0d", e, acc + 2); else pass_cnt++;
      total_cnt++; if (bus.o_dma_funct3 !== PIM_WRITE) $display("FAIL single_funct3: got %b want 001", bus.o_dma_funct3); else pass_cnt++;
      total_cnt++; if (bus.o_dma_sel_pim !== 4'd2) $display("FAIL single_sel: got %0d want 2", bus.o_dma_sel_pim); else pass_cnt++;
      total_cnt++; if (bus.o_dma_size !== 13'd16) $display("FAIL single_size: got %0d want 16", bus.o_dma_size); else pass_cnt++;
      total_cnt++; if (bus.o_dma_mem_addr !== 32'h1000) $display("FAIL single_addr: got %0h want 1000", bus.o_dma_mem_addr); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (bus.o_dma_en !== 1'b0) $display("FAIL single_pulse_width: en still %b a cycle later", bus.o_dma_en); else pass_cnt++;
      total_cnt++; if (bus.o_dma_mem_addr !== 32'h1000) $display("FAIL single_addr_hold: got %0h want 1000", bus.o_dma_mem_addr); else pass_cnt++;
      exp_done = 1;
      wait_done(exp_done);
      bus.i_fence = 1'b1;
      #1;
      total_cnt++; if (bus.o_fence_stall !== 1'b0) $display("FAIL single_idle: stall %b want 0 (dispatcher idle)", bus.o_fence_stall); else pass_cnt++;
      bus.i_fence = 1'b0;
      total_cnt++; if (dma_log.size() !== 1) $display("FAIL single_issue_count: got %0d want 1", dma_log.size()); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int acc, e, acc5;
      logic [31:0] exp_addr [6];
      logic [2:0]  exp_f3   [6];
      exp_addr = '{32'h2000, 32'h3000, 32'h3004, 32'h3008, 32'h300c, 32'h3010};
      exp_f3   = '{PIM_LOAD, PIM_WRITE, PIM_COMPUTE, PIM_LOAD, PIM_WRITE, PIM_COMPUTE};
      dma_log.delete();
      done_cyc_q.delete();
      dma_len = 30;
      push_cmd(exp_f3[0], exp_addr[0], 32'h0001_0008, acc);
      wait_en(e);
      @(posedge clk);
      dma_len = 6;
      for (int i = 1; i <= DEPTH; i++) push_cmd(exp_f3[i], exp_addr[i], 32'h0000_0000 | (32'(i) << 16) | 32'(i + 3), acc);
      @(negedge clk);
      total_cnt++; if (bus.o_cmd_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0 after 4 stored pushes", bus.o_cmd_ready); else pass_cnt++;
      push_cmd(exp_f3[5], exp_addr[5], 32'h0005_0009, acc5);
      exp_done += 6;
      wait_done(exp_done);
      total_cnt++; if (done_cyc_q.size() < 1 || acc5 !== done_cyc_q[0] + 1)
         $display("FAIL b2b_fifth_accept: accepted cycle %0d want %0d", acc5, (done_cyc_q.size() > 0) ? done_cyc_q[0] + 1 : -1); else pass_cnt++;
      total_cnt++; if (dma_log.size() !== 6) $display("FAIL b2b_issue_count: got %0d want 6", dma_log.size()); else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         if (i < dma_log.size()) begin
            total_cnt++; if (dma_log[i].mem_addr !== exp_addr[i] || dma_log[i].funct3 !== exp_f3[i])
               $display("FAIL b2b_order[%0d]: got addr %0h f3 %b want addr %0h f3 %b", i, dma_log[i].mem_addr, dma_log[i].funct3, exp_addr[i], exp_f3[i]); else pass_cnt++;
         end
      end
      total_cnt++; if (dma_log.size() > 3 && (dma_log[3].size !== 13'd6 || dma_log[3].sel_pim !== 4'd3))
         $display("FAIL b2b_operands: got size %0d sel %0d want 6 3", dma_log[3].size, dma_log[3].sel_pim); else pass_cnt++;
   endtask

   task automatic test_illegal();
      int acc;
      dma_log.delete();
      push_cmd(3'b011, 32'h0000_1000, 32'h0001_0010, acc);
      @(negedge clk);
      total_cnt++; if (bus.o_err_illegal !== 1'b1) $display("FAIL illegal_funct3: err %b want 1", bus.o_err_illegal); else pass_cnt++;
      clear_errs();
      total_cnt++; if (bus.o_err_illegal !== 1'b0) $display("FAIL illegal_clear: err %b want 0", bus.o_err_illegal); else pass_cnt++;
      push_cmd(PIM_COMPUTE, 32'h0000_1000, 32'h0001_0000, acc);
      @(negedge clk);
      total_cnt++; if (bus.o_err_illegal !== 1'b1) $display("FAIL illegal_size0: err %b want 1", bus.o_err_illegal); else pass_cnt++;
      clear_errs();
      bus.i_err_clr = 1'b1;
      push_cmd(PIM_WRITE, 32'h0000_1002, 32'h0001_0010, acc);
      @(negedge clk);
      total_cnt++; if (bus.o_err_illegal !== 1'b1) $display("FAIL illegal_align_set_wins: err %b want 1", bus.o_err_illegal); else pass_cnt++;
      bus.i_err_clr = 1'b0;
      repeat (10) @(negedge clk);
      total_cnt++; if (dma_log.size() !== 0) $display("FAIL illegal_dispatched: got %0d pulses want 0", dma_log.size()); else pass_cnt++;
      total_cnt++; if (bus.o_done_cnt !== 16'(exp_done)) $display("FAIL illegal_done: got %0d want %0d", bus.o_done_cnt, exp_done); else pass_cnt++;
      total_cnt++; if (bus.o_err_timeout !== 1'b0) $display("FAIL illegal_timeout_flag: got %b want 0", bus.o_err_timeout); else pass_cnt++;
      clear_errs();
   endtask

   task automatic test_timeout();
      int acc, e1, e2, c, n;
      dma_log.delete();
      dma_mute = 1'b1;
      push_cmd(PIM_LOAD, 32'h0000_4000, 32'h0001_0020, acc);
      push_cmd(PIM_WRITE, 32'h0000_4100, 32'h0002_0004, acc);
      wait_en(e1);
      n = 0;
      while (bus.o_err_timeout !== 1'b1 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      c = cyc;
      dma_mute = 1'b0;
      // Flag flop is set on the BT-th clock edge after the pulse cycle ends.
      total_cnt++; if (c !== e1 + BT + 1) $display("FAIL timeout_cycle: flag at cycle %0d want %0d", c, e1 + BT + 1); else pass_cnt++;
      total_cnt++; if (bus.o_done_cnt !== 16'(exp_done)) $display("FAIL timeout_not_counted: got %0d want %0d", bus.o_done_cnt, exp_done); else pass_cnt++;
      wait_en(e2);
      total_cnt++; if (e2 !== e1 + BT + 2) $display("FAIL timeout_next_issue: pulse at %0d want %0d", e2, e1 + BT + 2); else pass_cnt++;
      total_cnt++; if (bus.o_dma_mem_addr !== 32'h4100) $display("FAIL timeout_next_addr: got %0h want 4100", bus.o_dma_mem_addr); else pass_cnt++;
      exp_done += 1;
      wait_done(exp_done);
      clear_errs();
      dma_delay = BT;
      push_cmd(PIM_COMPUTE, 32'h0000_4200, 32'h0003_0001, acc);
      exp_done += 1;
      wait_done(exp_done);
      dma_delay = 0;
      total_cnt++; if (bus.o_err_timeout !== 1'b0) $display("FAIL timeout_late_busy_ok: flag %b want 0", bus.o_err_timeout); else pass_cnt++;
   endtask

   task automatic test_fence();
      int acc, n;
      bit dropped;
      dma_len = 5;
      push_cmd(PIM_WRITE, 32'h0000_5000, 32'h0001_0002, acc);
      push_cmd(PIM_LOAD, 32'h0000_5004, 32'h0001_0003, acc);
      @(negedge clk);
      bus.i_fence = 1'b1;
      #1;
      total_cnt++; if (bus.o_fence_stall !== 1'b1) $display("FAIL fence_assert: stall %b want 1", bus.o_fence_stall); else pass_cnt++;
      exp_done += 2;
      dropped = 1'b0;
      n = 0;
      while (bus.o_done_cnt !== 16'(exp_done) && n < BOUND) begin
         if (bus.o_fence_stall !== 1'b1) dropped = 1'b1;
         @(negedge clk);
         n++;
      end
      total_cnt++; if (n >= BOUND) $display("FAIL fence_done: done %0d want %0d", bus.o_done_cnt, exp_done); else pass_cnt++;
      total_cnt++; if (dropped !== 1'b0) $display("FAIL fence_held: stall dropped %b want 0 before second completion", dropped); else pass_cnt++;
      total_cnt++; if (bus.o_fence_stall !== 1'b0) $display("FAIL fence_release: stall %b want 0 after second busy fell", bus.o_fence_stall); else pass_cnt++;
      bus.i_fence = 1'b0;
   endtask

   task automatic test_reset_mid();
      int acc;
      dma_len = 40;
      push_cmd(3'b111, 32'h0000_6000, 32'h0001_0001, acc);
      dma_log.delete();
      for (int i = 0; i < 4; i++) push_cmd(PIM_COMPUTE, 32'h0000_6000 + 32'(i * 4), 32'h0001_0004, acc);
      repeat (3) @(negedge clk);
      total_cnt++; if (bus.o_err_illegal !== 1'b1) $display("FAIL rmid_pre_err: got %b want 1", bus.o_err_illegal); else pass_cnt++;
      total_cnt++; if (bus.i_dma_busy !== 1'b1 || dma_log.size() !== 1) $display("FAIL rmid_pre_busy: busy %b pulses %0d want 1 1", bus.i_dma_busy, dma_log.size()); else pass_cnt++;
      rst_n = 1'b0;
      bus.i_fence = 1'b1;
      #1;
      total_cnt++; if (bus.o_cmd_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", bus.o_cmd_ready); else pass_cnt++;
      total_cnt++; if ({bus.o_dma_en, bus.o_dma_funct3, bus.o_dma_sel_pim, bus.o_dma_size, bus.o_dma_mem_addr} !== 53'd0)
         $display("FAIL rmid_dma_outs: got %0h want 0", {bus.o_dma_en, bus.o_dma_funct3, bus.o_dma_sel_pim, bus.o_dma_size, bus.o_dma_mem_addr}); else pass_cnt++;
      total_cnt++; if ({bus.o_err_illegal, bus.o_err_timeout, bus.o_done_cnt} !== 18'd0)
         $display("FAIL rmid_status: got %0h want 0", {bus.o_err_illegal, bus.o_err_timeout, bus.o_done_cnt}); else pass_cnt++;
      total_cnt++; if (bus.o_fence_stall !== 1'b0) $display("FAIL rmid_empty: stall %b want 0", bus.o_fence_stall); else pass_cnt++;
      bus.i_fence = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_done = 0;
      repeat (10) @(negedge clk);
      total_cnt++; if (dma_log.size() !== 1) $display("FAIL rmid_dropped: got %0d pulses want 1", dma_log.size()); else pass_cnt++;
      total_cnt++; if (bus.o_cmd_ready !== 1'b1 || bus.o_done_cnt !== 16'(exp_done))
         $display("FAIL rmid_after: ready %b done %0d want 1 0", bus.o_cmd_ready, bus.o_done_cnt); else pass_cnt++;
   endtask

   initial begin
      bus.i_cmd_valid  = 1'b0;
      bus.i_cmd_funct3 = 3'b000;
      bus.i_cmd_rs1    = '0;
      bus.i_cmd_rs2    = '0;
      bus.i_fence      = 1'b0;
      bus.i_err_clr    = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_fence();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
